// File: rtl/ps2_mouse_cursor_pkg.sv
// Shared definitions for the PS/2 mouse cursor tracker: packet FSM states,
// status byte bit positions and the stored status fields.
package ps2_mouse_cursor_pkg;

  typedef enum logic [1:0] {
    WAIT_B1 = 2'd0,
    WAIT_B2 = 2'd1,
    WAIT_B3 = 2'd2
  } pkt_state_t;

  // Bit positions inside the PS/2 status (first) byte
  localparam int BTN_L    = 0;
  localparam int BTN_R    = 1;
  localparam int BTN_M    = 2;
  localparam int SYNC_BIT = 3;
  localparam int X_SIGN   = 4;
  localparam int Y_SIGN   = 5;
  localparam int X_OVF    = 6;
  localparam int Y_OVF    = 7;

  // Status fields kept for the rest of the packet (the sync bit is only
  // needed at acceptance time, so it is not stored)
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] btn;
  } ps2_status_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_axis_accum.sv
// One cursor axis: adds a signed delta to the position and saturates the
// result into 0..MAX. Recenter overrides any pending delta.
module ps2_axis_accum #(
  parameter int POS_W  = 10,
  parameter int CALC_W = 12,
  parameter int MAX    = 639,
  parameter int INIT   = 320
) (
  input  logic                     qzt_clk,
  input  logic                     reset,
  input  logic                     apply,
  input  logic                     recenter,
  input  logic signed [CALC_W-1:0] delta,
  output logic        [POS_W-1:0]  pos
);

  localparam logic signed [CALC_W-1:0] MAX_S  = CALC_W'(MAX);
  localparam logic        [POS_W-1:0]  INIT_P = POS_W'(INIT);

  // Saturate a signed sum into the legal screen range
  function automatic logic [POS_W-1:0] sat_pos(input logic signed [CALC_W-1:0] v);
    if (v[CALC_W-1]) return '0;
    if (v > MAX_S) return MAX_S[POS_W-1:0];
    return v[POS_W-1:0];
  endfunction

  logic signed [CALC_W-1:0] sum_p0;

  // Stage p0: widen position and add delta; wide enough that nothing wraps
  always_comb sum_p0 = signed'({{(CALC_W-POS_W){1'b0}}, pos}) + delta;

  // Stage p1: registered position, recenter has priority over a packet
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset)         pos <= INIT_P;
    else if (recenter) pos <= INIT_P;
    else if (apply)    pos <= sat_pos(sum_p0);
  end

endmodule

// File: rtl/ps2_mouse_cursor.sv
// PS/2 mouse cursor tracker: assembles 3-byte packets from the received
// byte stream, resynchronises on bad framing or inter-byte timeout, and
// maintains a clamped cursor position plus button levels/press pulses.
module ps2_mouse_cursor
  import ps2_mouse_cursor_pkg::*;
#(
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int SHIFT      = 0,
  parameter int TIMEOUT_MS = 20
) (
  input  logic           qzt_clk,
  input  logic           reset,
  input  logic           tick_ms,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  input  logic           recenter,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     buttons,
  output logic [2:0]     btn_press,
  output logic           pkt_valid,
  output logic           sync_err
);

  localparam int         CALC_W  = max3(X_W, Y_W, 9) + 2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_MS - 1);

  pkt_state_t  state_p0, state_nxt;
  logic [7:0]  to_cnt_p0, to_cnt_nxt;
  ps2_status_t status_p0;
  logic [7:0]  dx_byte_p0;
  logic        take_status, take_dx, vld_p0, rej_p0;

  logic signed [8:0]        dx9, dy9, dx_sh, dy_sh;
  logic signed [CALC_W-1:0] dx_ext, dy_ext, dy_neg;

  // Stage p0: packet FSM next state and inter-byte timeout; a byte always
  // wins over a coincident timeout expiry
  always_comb begin
    state_nxt   = state_p0;
    to_cnt_nxt  = to_cnt_p0;
    take_status = 1'b0;
    take_dx     = 1'b0;
    vld_p0      = 1'b0;
    rej_p0      = 1'b0;
    if (rx_valid) begin
      to_cnt_nxt = '0;
      case (state_p0)
        WAIT_B1: begin
          if (rx_data[SYNC_BIT]) begin
            take_status = 1'b1;
            state_nxt   = WAIT_B2;
          end else begin
            rej_p0 = 1'b1;
          end
        end
        WAIT_B2: begin
          take_dx   = 1'b1;
          state_nxt = WAIT_B3;
        end
        WAIT_B3: begin
          vld_p0    = 1'b1;
          state_nxt = WAIT_B1;
        end
        default: state_nxt = WAIT_B1;
      endcase
    end else if (tick_ms && (state_p0 != WAIT_B1)) begin
      if (to_cnt_p0 == TO_LAST) begin
        state_nxt  = WAIT_B1;
        to_cnt_nxt = '0;
      end else begin
        to_cnt_nxt = to_cnt_p0 + 8'd1;
      end
    end
  end

  // Stage p0 -> p1: FSM state and timeout counter registers
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state_p0  <= WAIT_B1;
      to_cnt_p0 <= '0;
    end else begin
      state_p0  <= state_nxt;
      to_cnt_p0 <= to_cnt_nxt;
    end
  end

  // Stage p0 -> p1: hold status and dx bytes until the dy byte arrives
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      status_p0  <= '0;
      dx_byte_p0 <= '0;
    end else begin
      if (take_status) begin
        status_p0.y_ovf  <= rx_data[Y_OVF];
        status_p0.x_ovf  <= rx_data[X_OVF];
        status_p0.y_sign <= rx_data[Y_SIGN];
        status_p0.x_sign <= rx_data[X_SIGN];
        status_p0.btn    <= {rx_data[BTN_M], rx_data[BTN_R], rx_data[BTN_L]};
      end
      if (take_dx) dx_byte_p0 <= rx_data;
    end
  end

  // Stage p0: 9-bit signed deltas, overflow squash, sensitivity shift;
  // Y is negated because PS/2 +dy means up while screen y grows downward
  always_comb begin
    dx9    = status_p0.x_ovf ? 9'sd0 : signed'({status_p0.x_sign, dx_byte_p0});
    dy9    = status_p0.y_ovf ? 9'sd0 : signed'({status_p0.y_sign, rx_data});
    dx_sh  = dx9 >>> SHIFT;
    dy_sh  = dy9 >>> SHIFT;
    dx_ext = signed'({{(CALC_W-9){dx_sh[8]}}, dx_sh});
    dy_ext = signed'({{(CALC_W-9){dy_sh[8]}}, dy_sh});
    dy_neg = -dy_ext;
  end

  ps2_axis_accum #(
    .POS_W (X_W),
    .CALC_W(CALC_W),
    .MAX   (X_MAX),
    .INIT  (X_INIT)
  ) u_x_accum (
    .qzt_clk (qzt_clk),
    .reset   (reset),
    .apply   (vld_p0),
    .recenter(recenter),
    .delta   (dx_ext),
    .pos     (x)
  );

  ps2_axis_accum #(
    .POS_W (Y_W),
    .CALC_W(CALC_W),
    .MAX   (Y_MAX),
    .INIT  (Y_INIT)
  ) u_y_accum (
    .qzt_clk (qzt_clk),
    .reset   (reset),
    .apply   (vld_p0),
    .recenter(recenter),
    .delta   (dy_neg),
    .pos     (y)
  );

  // Stage p1: button levels, press edges and single-cycle status pulses
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      buttons   <= '0;
      btn_press <= '0;
      pkt_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      pkt_valid <= vld_p0;
      sync_err  <= rej_p0;
      if (vld_p0) begin
        buttons   <= status_p0.btn;
        btn_press <= status_p0.btn & ~buttons;
      end else begin
        btn_press <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Bench for ps2_mouse_cursor: a SHIFT=0 and a SHIFT=2 instance share the
// same stimulus and are compared against a packet-level reference model.
module tb_ps2_mouse_cursor;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_ms = 1'b0;
  logic       rx_valid = 1'b0;
  logic       recenter = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic [9:0] x0, y0, x2, y2;
  logic [2:0] buttons0, press0, buttons2, press2;
  logic       pv0, pv2, se0, se2;

  always #10 clk = ~clk;

  ps2_mouse_cursor #(.SHIFT(0)) dut (
    .qzt_clk(clk), .reset(reset), .tick_ms(tick_ms), .rx_data(rx_data),
    .rx_valid(rx_valid), .recenter(recenter), .x(x0), .y(y0),
    .buttons(buttons0), .btn_press(press0), .pkt_valid(pv0), .sync_err(se0)
  );

  ps2_mouse_cursor #(.SHIFT(2)) dut_s2 (
    .qzt_clk(clk), .reset(reset), .tick_ms(tick_ms), .rx_data(rx_data),
    .rx_valid(rx_valid), .recenter(recenter), .x(x2), .y(y2),
    .buttons(buttons2), .btn_press(press2), .pkt_valid(pv2), .sync_err(se2)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state (index 0: SHIFT=0, index 1: SHIFT=2)
  int         exp_x[2];
  int         exp_y[2];
  logic [2:0] exp_btn, exp_press;
  logic       exp_pv, exp_se;
  logic [7:0] pend[$];
  int         idle;

  function automatic int floor_shift(input int v, input int sh);
    int d;
    d = 1 << sh;
    if (v >= 0) return v / d;
    return -(((-v) + d - 1) / d);
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    pend.delete();
    idle = 0;
    exp_x[0] = 320; exp_x[1] = 320;
    exp_y[0] = 240; exp_y[1] = 240;
    exp_btn = 3'b000; exp_press = 3'b000;
    exp_pv = 1'b0; exp_se = 1'b0;
  endtask

  task automatic model_apply();
    logic [7:0] s;
    int dx, dy, sh;
    s  = pend[0];
    dx = s[6] ? 0 : (s[4] ? int'(pend[1]) - 256 : int'(pend[1]));
    dy = s[7] ? 0 : (s[5] ? int'(pend[2]) - 256 : int'(pend[2]));
    for (int k = 0; k < 2; k++) begin
      sh = (k == 0) ? 0 : 2;
      exp_x[k] = clampi(exp_x[k] + floor_shift(dx, sh), 639);
      exp_y[k] = clampi(exp_y[k] - floor_shift(dy, sh), 479);
    end
    exp_press = s[2:0] & ~exp_btn;
    exp_btn   = s[2:0];
    exp_pv    = 1'b1;
    pend.delete();
  endtask

  // Drive one clock cycle of inputs and advance the model to match
  task automatic cyc(input logic v, input logic [7:0] d, input logic t, input logic r);
    rx_valid = v; rx_data = d; tick_ms = t; recenter = r;
    @(posedge clk); #1;
    rx_valid = 1'b0; tick_ms = 1'b0; recenter = 1'b0;
    exp_pv = 1'b0; exp_se = 1'b0; exp_press = 3'b000;
    if (v) begin
      idle = 0;
      if (pend.size() == 0 && !d[3]) exp_se = 1'b1;
      else begin
        pend.push_back(d);
        if (pend.size() == 3) model_apply();
      end
    end else if (t && pend.size() > 0) begin
      idle++;
      if (idle == TO) begin
        pend.delete();
        idle = 0;
      end
    end
    if (r) begin
      exp_x[0] = 320; exp_x[1] = 320;
      exp_y[0] = 240; exp_y[1] = 240;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b1); send_byte(b2); send_byte(b3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (x0 !== 10'd320) begin failures++; $display("FAIL reset_x got=%0d want=320", x0); end
    checks++; if (y0 !== 10'd240) begin failures++; $display("FAIL reset_y got=%0d want=240", y0); end
    checks++; if (buttons0 !== 3'b000) begin failures++; $display("FAIL reset_buttons got=%b want=000", buttons0); end
    checks++; if (press0 !== 3'b000) begin failures++; $display("FAIL reset_press got=%b want=000", press0); end
    checks++; if (pv0 !== 1'b0) begin failures++; $display("FAIL reset_pkt_valid got=%b want=0", pv0); end
    checks++; if (se0 !== 1'b0) begin failures++; $display("FAIL reset_sync_err got=%b want=0", se0); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send_byte(8'h08); send_byte(8'h05);
    checks++; if (pv0 !== 1'b0) begin failures++; $display("FAIL basic_early_pv got=%b want=0", pv0); end
    send_byte(8'h03);
    checks++; if (x0 !== 10'd325) begin failures++; $display("FAIL basic_x got=%0d want=325", x0); end
    checks++; if (y0 !== 10'd237) begin failures++; $display("FAIL basic_y got=%0d want=237", y0); end
    checks++; if (pv0 !== 1'b1) begin failures++; $display("FAIL basic_pv got=%b want=1", pv0); end
    checks++; if (buttons0 !== 3'b000) begin failures++; $display("FAIL basic_buttons got=%b want=000", buttons0); end
    checks++; if (x2 !== 10'd321) begin failures++; $display("FAIL basic_x_s2 got=%0d want=321", x2); end
    checks++; if (y2 !== 10'd240) begin failures++; $display("FAIL basic_y_s2 got=%0d want=240", y2); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (pv0 !== 1'b0) begin failures++; $display("FAIL basic_pv_drop got=%b want=0", pv0); end
  endtask

  task automatic test_clamp();
    send_pkt(8'h18, 8'h00, 8'h00);
    send_pkt(8'h18, 8'h00, 8'h00);
    send_pkt(8'h08, 8'h05, 8'h00);
    checks++; if (x0 !== 10'd5) begin failures++; $display("FAIL clamp_setup_x got=%0d want=5", x0); end
    send_pkt(8'h18, 8'hF6, 8'h00);
    checks++; if (x0 !== 10'd0) begin failures++; $display("FAIL clamp_low_x got=%0d want=0", x0); end
    checks++; if (y0 !== 10'd237) begin failures++; $display("FAIL clamp_low_y got=%0d want=237", y0); end
    repeat (3) send_pkt(8'h08, 8'hFF, 8'h00);
    send_pkt(8'h18, 8'hFC, 8'h00);
    checks++; if (x0 !== 10'd635) begin failures++; $display("FAIL clamp_setup_hi got=%0d want=635", x0); end
    send_pkt(8'h08, 8'h0A, 8'h00);
    checks++; if (x0 !== 10'd639) begin failures++; $display("FAIL clamp_high_x got=%0d want=639", x0); end
    send_pkt(8'h08, 8'h00, 8'hFF);
    checks++; if (y0 !== 10'd0) begin failures++; $display("FAIL clamp_top_y got=%0d want=0", y0); end
    send_pkt(8'h28, 8'h00, 8'h00);
    send_pkt(8'h28, 8'h00, 8'h00);
    checks++; if (y0 !== 10'd479) begin failures++; $display("FAIL clamp_bottom_y got=%0d want=479", y0); end
    checks++; if (x2 !== 10'(exp_x[1])) begin failures++; $display("FAIL clamp_x_s2 got=%0d want=%0d", x2, exp_x[1]); end
    checks++; if (y2 !== 10'(exp_y[1])) begin failures++; $display("FAIL clamp_y_s2 got=%0d want=%0d", y2, exp_y[1]); end
  endtask

  task automatic test_sync_err();
    int xb, yb;
    xb = exp_x[0]; yb = exp_y[0];
    send_byte(8'h00);
    checks++; if (se0 !== 1'b1) begin failures++; $display("FAIL sync_err_pulse got=%b want=1", se0); end
    checks++; if (pv0 !== 1'b0) begin failures++; $display("FAIL sync_err_pv got=%b want=0", pv0); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (se0 !== 1'b0) begin failures++; $display("FAIL sync_err_drop got=%b want=0", se0); end
    send_pkt(8'h09, 8'h00, 8'h00);
    checks++; if (buttons0 !== 3'b001) begin failures++; $display("FAIL sync_buttons got=%b want=001", buttons0); end
    checks++; if (press0 !== 3'b001) begin failures++; $display("FAIL sync_press got=%b want=001", press0); end
    checks++; if (x0 !== 10'(xb) || y0 !== 10'(yb)) begin failures++; $display("FAIL sync_pos got=%0d,%0d want=%0d,%0d", x0, y0, xb, yb); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (press0 !== 3'b000) begin failures++; $display("FAIL sync_press_drop got=%b want=000", press0); end
    checks++; if (buttons0 !== 3'b001) begin failures++; $display("FAIL sync_buttons_hold got=%b want=001", buttons0); end
    send_pkt(8'h0B, 8'h00, 8'h00);
    checks++; if (press0 !== 3'b010) begin failures++; $display("FAIL sync_press_edge got=%b want=010", press0); end
    send_pkt(8'h08, 8'h00, 8'h00);
  endtask

  task automatic test_timeout();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (x0 !== 10'd320 || y0 !== 10'd240) begin failures++; $display("FAIL recenter_pos got=%0d,%0d want=320,240", x0, y0); end
    send_byte(8'h08); send_byte(8'h05);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    send_pkt(8'h08, 8'h01, 8'h01);
    checks++; if (x0 !== 10'd321) begin failures++; $display("FAIL timeout_x got=%0d want=321", x0); end
    checks++; if (y0 !== 10'd239) begin failures++; $display("FAIL timeout_y got=%0d want=239", y0); end
    checks++; if (pv0 !== 1'b1) begin failures++; $display("FAIL timeout_pv got=%b want=1", pv0); end
    send_byte(8'h08); send_byte(8'h01);
    for (int i = 0; i < 19; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    send_byte(8'h01);
    checks++; if (pv0 !== 1'b1 || x0 !== 10'd322) begin failures++; $display("FAIL timeout_19_ticks got=pv%b x%0d want=pv1 x322", pv0, x0); end
    send_byte(8'h08);
    for (int i = 0; i < 19; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h02, 1'b1, 1'b0);
    send_byte(8'h00);
    checks++; if (pv0 !== 1'b1 || x0 !== 10'd324) begin failures++; $display("FAIL timeout_byte_wins got=pv%b x%0d want=pv1 x324", pv0, x0); end
  endtask

  task automatic test_overflow();
    int xb, yb, xb2, yb2;
    xb = exp_x[0]; yb = exp_y[0];
    send_pkt(8'h48, 8'hFF, 8'h02);
    checks++; if (x0 !== 10'(xb)) begin failures++; $display("FAIL ovf_x got=%0d want=%0d", x0, xb); end
    checks++; if (y0 !== 10'(yb - 2)) begin failures++; $display("FAIL ovf_y got=%0d want=%0d", y0, yb - 2); end
    xb = exp_x[0]; yb = exp_y[0]; xb2 = exp_x[1]; yb2 = exp_y[1];
    send_pkt(8'h28, 8'h08, 8'hF8);
    checks++; if (x2 !== 10'(xb2 + 2) || y2 !== 10'(yb2 + 2)) begin failures++; $display("FAIL shift2_pos got=%0d,%0d want=%0d,%0d", x2, y2, xb2 + 2, yb2 + 2); end
    checks++; if (x0 !== 10'(xb + 8) || y0 !== 10'(yb + 8)) begin failures++; $display("FAIL shift0_pos got=%0d,%0d want=%0d,%0d", x0, y0, xb + 8, yb + 8); end
    xb2 = exp_x[1];
    send_pkt(8'h18, 8'hFF, 8'h00);
    checks++; if (x2 !== 10'(xb2 - 1)) begin failures++; $display("FAIL shift2_floor got=%0d want=%0d", x2, xb2 - 1); end
  endtask

  task automatic test_recenter_apply();
    send_byte(8'h0A); send_byte(8'h7F);
    cyc(1'b1, 8'h7F, 1'b0, 1'b1);
    checks++; if (x0 !== 10'd320 || y0 !== 10'd240) begin failures++; $display("FAIL recenter_apply_pos got=%0d,%0d want=320,240", x0, y0); end
    checks++; if (pv0 !== 1'b1) begin failures++; $display("FAIL recenter_apply_pv got=%b want=1", pv0); end
    checks++; if (buttons0 !== 3'b010 || press0 !== 3'b010) begin failures++; $display("FAIL recenter_apply_btn got=%b/%b want=010/010", buttons0, press0); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h08); send_byte(8'h01);
    reset = 1'b1;
    #5;
    model_reset();
    checks++; if (x0 !== 10'd320 || buttons0 !== 3'b000) begin failures++; $display("FAIL async_reset got=x%0d b%b want=x320 b000", x0, buttons0); end
    reset = 1'b0;
    send_pkt(8'h08, 8'h01, 8'h00);
    checks++; if (x0 !== 10'd321 || y0 !== 10'd240) begin failures++; $display("FAIL reset_mid_pos got=%0d,%0d want=321,240", x0, y0); end
  endtask

  task automatic test_back_to_back();
    logic       v, t, r;
    logic [7:0] d;
    int         vpct;
    for (int n = 0; n < 1200; n++) begin
      vpct = (n < 600) ? 75 : 3;
      v = ($urandom_range(0, 99) < vpct);
      t = (n < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      r = ($urandom_range(0, 99) < 2);
      d = 8'($urandom);
      if (pend.size() == 0) d[3] = ($urandom_range(0, 9) != 0);
      cyc(v, d, t, r);
      checks++; if (x0 !== 10'(exp_x[0]) || y0 !== 10'(exp_y[0])) begin failures++; $display("FAIL rand_pos n=%0d got=%0d,%0d want=%0d,%0d", n, x0, y0, exp_x[0], exp_y[0]); end
      checks++; if (x2 !== 10'(exp_x[1]) || y2 !== 10'(exp_y[1])) begin failures++; $display("FAIL rand_pos_s2 n=%0d got=%0d,%0d want=%0d,%0d", n, x2, y2, exp_x[1], exp_y[1]); end
      checks++; if (buttons0 !== exp_btn || press0 !== exp_press) begin failures++; $display("FAIL rand_btn n=%0d got=%b/%b want=%b/%b", n, buttons0, press0, exp_btn, exp_press); end
      checks++; if (pv0 !== exp_pv || se0 !== exp_se || pv2 !== exp_pv || se2 !== exp_se) begin failures++; $display("FAIL rand_pulse n=%0d got=pv%b se%b want=pv%b se%b", n, pv0, se0, exp_pv, exp_se); end
      checks++; if (buttons2 !== exp_btn || press2 !== exp_press) begin failures++; $display("FAIL rand_btn_s2 n=%0d got=%b/%b want=%b/%b", n, buttons2, press2, exp_btn, exp_press); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_sync_err();
    test_timeout();
    test_overflow();
    test_recenter_apply();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
